// File: rtl/HighLevelControl.sv
// ============================================================================
// Package : HighLevelControl
// Brief   : Shared control-path types; truncType selects the access size.
// Rev     : 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`ifdef XLEN_64
`define XLEN 64
`else
`define XLEN 32
`endif
`endif

package HighLevelControl;

    typedef enum logic [2:0] {
        BYTE               = 3'd0,
        HALF_WORD          = 3'd1,
        WORD               = 3'd2,
        NO_TRUNC           = 3'd3,
        BYTE_UNSIGNED      = 3'd4,
        HALF_WORD_UNSIGNED = 3'd5,
        WORD_UNSIGNED      = 3'd6
    } truncType;

endpackage

`default_nettype wire

// File: rtl/store_aligner_if.sv
// ============================================================================
// Interface : store_aligner_if
// Brief     : Store request side plus memory write side of the store aligner.
// Rev       : 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`ifdef XLEN_64
`define XLEN 64
`else
`define XLEN 32
`endif
`endif

interface store_aligner_if;
    import HighLevelControl::*;

    logic                 StoreValid;
    logic                 StoreReady;
    truncType             StoreType;
    logic [`XLEN-1:0]     StoreAddress;
    logic [`XLEN-1:0]     StoreData;
    logic                 StoreMisaligned;
    logic                 StoreIllegalType;
    logic                 MemWriteValid;
    logic                 MemWriteReady;
    logic [`XLEN-1:0]     MemWriteAddress;
    logic [`XLEN-1:0]     MemWriteData;
    logic [`XLEN/8-1:0]   MemWriteMask;
    logic                 StoreBufferEmpty;

    modport slave (
        input  StoreValid, StoreType, StoreAddress, StoreData, MemWriteReady,
        output StoreReady, StoreMisaligned, StoreIllegalType, MemWriteValid,
               MemWriteAddress, MemWriteData, MemWriteMask, StoreBufferEmpty
    );

    modport master (
        output StoreValid, StoreType, StoreAddress, StoreData, MemWriteReady,
        input  StoreReady, StoreMisaligned, StoreIllegalType, MemWriteValid,
               MemWriteAddress, MemWriteData, MemWriteMask, StoreBufferEmpty
    );

endinterface

`default_nettype wire

// File: rtl/store_aligner.sv
// ============================================================================
// Module : store_aligner
// Brief  : Lane-aligns store data, builds byte masks, drops faulting stores
//          and queues legal ones in an in-order FIFO toward data memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`ifdef XLEN_64
`define XLEN 64
`else
`define XLEN 32
`endif
`endif

module store_aligner
    import HighLevelControl::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    store_aligner_if.slave bus
);

    localparam int c_xlen = `XLEN;
    localparam int c_mw   = c_xlen / 8;
    localparam int c_offw = $clog2(c_mw);
    localparam int c_pw   = $clog2(DEPTH);
    localparam int c_cw   = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

    logic [c_xlen-1:0] r_addr_q [DEPTH];
    logic [c_xlen-1:0] r_data_q [DEPTH];
    logic [c_mw-1:0]   r_mask_q [DEPTH];
    logic [c_pw-1:0]   r_wptr;
    logic [c_pw-1:0]   r_rptr;
    logic [c_cw-1:0]   r_count;
    logic              r_misaligned;
    logic              r_illegal;

    logic [c_offw-1:0] w_off;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_illegal;
    logic              w_misaligned;
    logic              w_enq;
    logic              w_deq;
    logic              w_head_valid;
    logic [c_xlen-1:0] w_trunc;
    logic [c_xlen-1:0] w_lane_data;
    logic [c_mw-1:0]   w_lane_mask;

    assign w_off    = bus.StoreAddress[c_offw-1:0];
    assign w_full   = (r_count == c_full);
    assign w_empty  = (r_count == '0);
    assign w_accept = bus.StoreValid && !w_full;

    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_trunc      = '0;
        w_lane_mask  = '0;
        case (bus.StoreType)
            BYTE: begin
                w_trunc     = bus.StoreData & c_xlen'(8'hFF);
                w_lane_mask = c_mw'(1) << w_off;
            end
            HALF_WORD: begin
                w_misaligned = w_off[0];
                w_trunc      = bus.StoreData & c_xlen'(16'hFFFF);
                w_lane_mask  = c_mw'(2'b11) << w_off;
            end
            WORD: begin
                w_misaligned = (w_off[1:0] != 2'b00);
                w_trunc      = bus.StoreData & c_xlen'(32'hFFFF_FFFF);
                w_lane_mask  = c_mw'(4'hF) << w_off;
            end
            NO_TRUNC: begin
                w_misaligned = (w_off != '0);
                w_trunc      = bus.StoreData;
                w_lane_mask  = '1;
            end
            // Unsigned variants are load-only; the unused encoding is rejected too.
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_lane_data  = w_trunc << {w_off, 3'b000};
    assign w_enq        = w_accept && !w_illegal && !w_misaligned;
    assign w_head_valid = !w_empty && !reset;
    assign w_deq        = w_head_valid && bus.MemWriteReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_misaligned <= w_accept && !w_illegal && w_misaligned;
            r_illegal    <= w_accept && w_illegal;
            if (w_enq) begin
                r_wptr <= r_wptr + c_pw'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + c_pw'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + c_cw'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - c_cw'(1);
            end
        end
    end

    // Payload storage needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            r_addr_q[r_wptr] <= {bus.StoreAddress[c_xlen-1:c_offw], {c_offw{1'b0}}};
            r_data_q[r_wptr] <= w_lane_data;
            r_mask_q[r_wptr] <= w_lane_mask;
        end
    end

    assign bus.StoreReady       = !w_full;
    assign bus.StoreMisaligned  = r_misaligned;
    assign bus.StoreIllegalType = r_illegal;
    assign bus.StoreBufferEmpty = w_empty;
    assign bus.MemWriteValid    = w_head_valid;
    assign bus.MemWriteAddress  = w_empty ? '0 : r_addr_q[r_rptr];
    assign bus.MemWriteData     = w_empty ? '0 : r_data_q[r_rptr];
    assign bus.MemWriteMask     = w_empty ? '0 : r_mask_q[r_rptr];

endmodule

`default_nettype wire

// File: tb/tb_store_aligner.sv
// ============================================================================
// Module : tb_store_aligner
// Brief  : Directed self-checking bench for store_aligner (32-bit build).
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`ifdef XLEN_64
`define XLEN 64
`else
`define XLEN 32
`endif
`endif

module tb_store_aligner;
    import HighLevelControl::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    store_aligner_if bus ();

    store_aligner #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input truncType t, input logic [31:0] a, input logic [31:0] d);
        bus.StoreValid   = v;
        bus.StoreType    = t;
        bus.StoreAddress = a;
        bus.StoreData    = d;
    endtask

    initial begin
        logic [31:0] e_data;
        logic [3:0]  e_mask;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(1'b0, BYTE, 32'h0, 32'h0);
        bus.MemWriteReady = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_ready", bus.StoreReady, 1);
        check("rst_valid", bus.MemWriteValid, 0);
        check("rst_empty", bus.StoreBufferEmpty, 1);
        check("rst_mis", bus.StoreMisaligned, 0);
        check("rst_ill", bus.StoreIllegalType, 0);
        check("rst_addr", bus.MemWriteAddress, 0);
        check("rst_data", bus.MemWriteData, 0);
        check("rst_mask", bus.MemWriteMask, 0);

        // 1: byte store to lane 3
        bus.MemWriteReady = 1'b1;
        drive(1'b1, BYTE, 32'h1003, 32'h0000_00AB);
        tick();
        bus.StoreValid = 1'b0;
        check("t1_valid", bus.MemWriteValid, 1);
        check("t1_addr", bus.MemWriteAddress, 32'h1000);
        check("t1_data", bus.MemWriteData, 32'hAB00_0000);
        check("t1_mask", bus.MemWriteMask, 4'b1000);
        tick();
        check("t1_valid_off", bus.MemWriteValid, 0);
        check("t1_empty", bus.StoreBufferEmpty, 1);

        // 2: half-word upper lanes, then misaligned half-word
        drive(1'b1, HALF_WORD, 32'h2002, 32'h1234_BEEF);
        tick();
        bus.StoreValid = 1'b0;
        check("t2_addr", bus.MemWriteAddress, 32'h2000);
        check("t2_data", bus.MemWriteData, 32'hBEEF_0000);
        check("t2_mask", bus.MemWriteMask, 4'b1100);
        tick();
        drive(1'b1, HALF_WORD, 32'h2001, 32'h1234_BEEF);
        tick();
        bus.StoreValid = 1'b0;
        check("t2_mis_pulse", bus.StoreMisaligned, 1);
        check("t2_mis_ill", bus.StoreIllegalType, 0);
        check("t2_mis_empty", bus.StoreBufferEmpty, 1);
        check("t2_mis_valid", bus.MemWriteValid, 0);
        tick();
        check("t2_mis_clear", bus.StoreMisaligned, 0);

        // 3: fill with memory stalled, 5th stalls, then in-order drain
        bus.MemWriteReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, WORD, 32'(4 * i), 32'(i + 1));
            tick();
        end
        check("t3_full_ready", bus.StoreReady, 0);
        check("t3_full_empty", bus.StoreBufferEmpty, 0);
        drive(1'b1, WORD, 32'h10, 32'd5);
        tick();
        check("t3_stall_ready", bus.StoreReady, 0);
        check("t3_stall_head", bus.MemWriteData, 32'd1);
        check("t3_stall_addr", bus.MemWriteAddress, 32'h0);
        bus.MemWriteReady = 1'b1;
        tick();
        check("t3_ready_back", bus.StoreReady, 1);
        bus.StoreValid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("t3_drain_data", bus.MemWriteData, 32'(i + 1));
            check("t3_drain_addr", bus.MemWriteAddress, 32'(4 * i));
            check("t3_drain_mask", bus.MemWriteMask, 4'hF);
            tick();
        end
        check("t3_drained", bus.StoreBufferEmpty, 1);

        // 4: steady state at two entries with concurrent enq/deq
        bus.MemWriteReady = 1'b0;
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, BYTE, 32'h100 + 32'(j % 4), 32'(8'h11 * (j + 1)));
            tick();
        end
        bus.MemWriteReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, BYTE, 32'h100 + 32'((k + 2) % 4), 32'(8'h11 * (k + 3)));
            e_data = 32'(8'h11 * (k + 1)) << (8 * (k % 4));
            e_mask = 4'b0001 << (k % 4);
            check("t4_head_data", bus.MemWriteData, e_data);
            check("t4_head_mask", bus.MemWriteMask, e_mask);
            check("t4_ready", bus.StoreReady, 1);
            tick();
        end
        bus.StoreValid = 1'b0;
        for (int k = 4; k < 6; k++) begin
            e_data = 32'(8'h11 * (k + 1)) << (8 * (k % 4));
            check("t4_tail_data", bus.MemWriteData, e_data);
            tick();
        end
        check("t4_empty", bus.StoreBufferEmpty, 1);

        // 5: unsigned types are illegal, and win over misalignment
        drive(1'b1, BYTE_UNSIGNED, 32'h3000, 32'h55);
        tick();
        bus.StoreValid = 1'b0;
        check("t5_ill", bus.StoreIllegalType, 1);
        check("t5_mis", bus.StoreMisaligned, 0);
        check("t5_empty", bus.StoreBufferEmpty, 1);
        tick();
        check("t5_ill_clear", bus.StoreIllegalType, 0);
        drive(1'b1, HALF_WORD_UNSIGNED, 32'h3001, 32'h55);
        tick();
        bus.StoreValid = 1'b0;
        check("t5b_ill", bus.StoreIllegalType, 1);
        check("t5b_mis", bus.StoreMisaligned, 0);
        tick();

        // 6: full-width store, truncation and word misalignment
        drive(1'b1, NO_TRUNC, 32'h8, 32'h89AB_CDEF);
        tick();
        bus.StoreValid = 1'b0;
        check("t6_nt_data", bus.MemWriteData, 32'h89AB_CDEF);
        check("t6_nt_mask", bus.MemWriteMask, 4'hF);
        check("t6_nt_addr", bus.MemWriteAddress, 32'h8);
        tick();
        drive(1'b1, HALF_WORD, 32'h4000, 32'hFFFF_1234);
        tick();
        bus.StoreValid = 1'b0;
        check("t6_hw_data", bus.MemWriteData, 32'h0000_1234);
        check("t6_hw_mask", bus.MemWriteMask, 4'b0011);
        tick();
        drive(1'b1, WORD, 32'h6, 32'h1);
        tick();
        bus.StoreValid = 1'b0;
        check("t6_word_mis", bus.StoreMisaligned, 1);
        check("t6_word_empty", bus.StoreBufferEmpty, 1);
        tick();
        drive(1'b1, NO_TRUNC, 32'h9, 32'h1);
        tick();
        bus.StoreValid = 1'b0;
        check("t6_nt_mis", bus.StoreMisaligned, 1);
        tick();

        // 7: reset with three entries queued
        bus.MemWriteReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, WORD, 32'h500 + 32'(4 * i), 32'(i + 7));
            tick();
        end
        check("t7_queued", bus.MemWriteValid, 1);
        reset = 1'b1;
        bus.MemWriteReady = 1'b1;
        drive(1'b1, BYTE, 32'h600, 32'h1);
        #1;
        check("t7_no_write_in_reset", bus.MemWriteValid, 0);
        tick();
        reset = 1'b0;
        bus.StoreValid = 1'b0;
        check("t7_empty", bus.StoreBufferEmpty, 1);
        check("t7_valid", bus.MemWriteValid, 0);
        check("t7_ready", bus.StoreReady, 1);
        check("t7_mis", bus.StoreMisaligned, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_aligner.md
Name: store_aligner

Overview:
Store-side counterpart of the writeback load truncator. It accepts store requests from the memory stage: store type (HighLevelControl::truncType), byte address and register data. For each store it places the data in the correct byte lanes of an XLEN-wide memory word, generates the byte-write mask and checks alignment. Legal stores are queued in a small in-order FIFO that drains to the data memory over a valid/ready handshake.

Parameters:
DEPTH, 4, store FIFO entries; power of two, >= 2.
(XLEN comes from `XLEN in parameters.svh; XLEN_64 selects 64-bit. OFFW = $clog2(`XLEN/8).)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
StoreValid  input  1  store request present
StoreReady  output  1  store request can be accepted
StoreType  input  HighLevelControl::truncType  BYTE/HALF_WORD/WORD/NO_TRUNC (full XLEN)
StoreAddress  input  `XLEN  byte address
StoreData  input  `XLEN  register data, right-justified
StoreMisaligned  output  1  one-cycle pulse: accepted store was misaligned, dropped
StoreIllegalType  output  1  one-cycle pulse: accepted store had an unsigned type, dropped
MemWriteValid  output  1  head entry valid
MemWriteReady  input  1  memory accepts write
MemWriteAddress  output  `XLEN  word-aligned address (low OFFW bits zero)
MemWriteData  output  `XLEN  lane-aligned data
MemWriteMask  output  `XLEN/8  byte enables
StoreBufferEmpty  output  1  FIFO empty (fence/drain indication)

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: FIFO empty, read/write pointers and count 0. StoreReady=1, MemWriteValid=0, StoreBufferEmpty=1, StoreMisaligned=0, StoreIllegalType=0. MemWriteAddress, MemWriteData and MemWriteMask are 0 while the FIFO is empty.
- Accept: a store is accepted when StoreValid && StoreReady. StoreReady = !full. A same-cycle dequeue does not free a slot for that cycle's enqueue.
- Offset: off = StoreAddress[OFFW-1:0].
- Misalignment:
  - HALF_WORD: off[0]!=0.
  - WORD: off[1:0]!=0.
  - NO_TRUNC: off!=0.
  - BYTE: never misaligned.
- Type check: BYTE_UNSIGNED, HALF_WORD_UNSIGNED and WORD_UNSIGNED are illegal. Illegal takes priority over misaligned.
- Faulting stores: an accepted misaligned or illegal store is not enqueued. The matching pulse is registered and asserts for exactly the cycle after acceptance.
- Legal store alignment:
  - Enqueued address = StoreAddress with the low OFFW bits cleared.
  - Data = StoreData truncated to size, shifted left by off*8; lanes outside the store are 0.
  - Mask: BYTE 1<<off; HALF_WORD 2'b11<<off; WORD 4'hF<<off; NO_TRUNC all ones.
- Latency: an entry enqueued in cycle N is visible at the head (MemWriteValid=1) from cycle N+1. The head outputs come straight from FIFO storage.
- Dequeue: dequeue occurs when MemWriteValid && MemWriteReady. Head outputs stay stable while MemWriteValid=1 and MemWriteReady=0.
- FIFO order: strict in-order. Pointers wrap modulo DEPTH. full = (count==DEPTH), StoreBufferEmpty = (count==0).
- Simultaneous enqueue and dequeue (not full): count unchanged, both pointers advance.
- Reset mid-operation: all queued stores are discarded, no write is issued in the reset cycle, and pending pulses are cleared.
- Unused address bits above XLEN: none; full addresses are passed through.

Test Plan:
1. XLEN=32, BYTE, addr 0x1003, data 0x000000AB, MemWriteReady=1 -> next cycle MemWriteAddress=0x1000, Data=0xAB000000, Mask=4'b1000, Valid for 1 cycle; Empty again after.
2. HALF_WORD, addr 0x2002, data 0x1234BEEF -> Data=0xBEEF0000, Mask=4'b1100. Then HALF_WORD addr 0x2001 -> StoreMisaligned pulses 1 cycle, nothing enqueued, Empty stays 1.
3. MemWriteReady=0; issue 4 WORD stores to 0x0,0x4,0x8,0xC (data 1..4) -> StoreReady=0 after the 4th; a 5th request stalls. Raise MemWriteReady -> drain in order 1,2,3,4 with Mask=4'hF; StoreReady returns 1 the cycle after the first dequeue.
4. Count=2 with MemWriteReady=1 and a new BYTE store each cycle -> enqueue and dequeue coincide, count holds at 2, order is preserved.
5. StoreType=BYTE_UNSIGNED -> StoreIllegalType pulses, StoreMisaligned stays 0, no enqueue. A misaligned HALF_WORD_UNSIGNED raises only StoreIllegalType.
6. XLEN_64: NO_TRUNC addr 0x8, data 0x0123456789ABCDEF -> Mask=8'hFF, Data unchanged; WORD addr 0xC, data 0xCAFEF00D -> Data=0xCAFEF00D00000000, Mask=8'hF0. Assert reset with 3 entries queued -> next cycle Empty=1, MemWriteValid=0.
